// File: rtl/bomb_placer.sv
// Places num_bombs bombs on an 8x8 board from an external random cell source,
// linear-probing past occupied cells and the safe cell. Optional NEIGHBOR_COUNT_EN
// adds a registered neighbour-bomb counter for a queried cell.
module bomb_placer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  num_bombs,
    input  logic [5:0]  safe_cell,
    output logic        enable_random,
    input  logic [5:0]  randomValue,
    output logic [63:0] bomb_map,
    output logic [5:0]  placed_count,
    output logic        busy,
`ifdef NEIGHBOR_COUNT_EN
    input  logic [5:0]  query_cell,
    output logic [3:0]  query_count,
`endif
    output logic        done
);

    typedef enum logic [2:0] {IDLE, REQ, CHECK, PROBE, FINISH} state_t;

    state_t      state, state_n;
    logic [5:0]  num_q, safe_q;
    logic [5:0]  cand, cand_n;
    logic [5:0]  test_cell;
    logic        load, place;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bomb_map     <= '0;
            placed_count <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                bomb_map     <= '0;
                placed_count <= '0;
            end else if (place) begin
                bomb_map[test_cell] <= 1'b1;
                placed_count        <= placed_count + 6'd1;
            end
        end
    end

    // Job parameters and probe cursor carry no control meaning outside a run.
    always_ff @(posedge clk) begin
        cand <= cand_n;
        if (load) begin
            num_q  <= num_bombs;
            safe_q <= safe_cell;
        end
    end

    always_comb begin
        state_n       = state;
        cand_n        = cand;
        enable_random = 1'b0;
        done          = 1'b0;
        busy          = (state != IDLE);
        load          = 1'b0;
        place         = 1'b0;
        test_cell     = cand;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = (num_bombs == 6'd0) ? FINISH : REQ;
                end
            end
            REQ: begin
                enable_random = 1'b1;
                state_n       = CHECK;
            end
            CHECK, PROBE: begin
                test_cell = (state == CHECK) ? randomValue : cand;
                if (!bomb_map[test_cell] && (test_cell != safe_q)) begin
                    place   = 1'b1;
                    state_n = ((placed_count + 6'd1) == num_q) ? FINISH : REQ;
                end else begin
                    // 6-bit increment wraps 63 back to 0
                    cand_n  = test_cell + 6'd1;
                    state_n = PROBE;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef NEIGHBOR_COUNT_EN
    function automatic logic [3:0] nbr_count(input logic [63:0] m, input logic [5:0] c);
        logic [3:0] n;
        int r, k;
        n = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(c[5:3]) + dr;
                k = int'(c[2:0]) + dc;
                if (!(dr == 0 && dc == 0) && r >= 0 && r < 8 && k >= 0 && k < 8) begin
                    if (m[6'(r * 8 + k)]) n = n + 4'd1;
                end
            end
        end
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) query_count <= 4'd0;
        else     query_count <= nbr_count(bomb_map, query_cell);
    end
`endif

endmodule

// File: tb/tb_bomb_placer.sv
// Scoreboard bench for bomb_placer: boards are predicted by a probing model from
// the random values fed to the DUT; a monitor checks each done pulse.
module tb_bomb_placer;

    logic        clk = 1'b0;
    logic        rst, start, enable_random, busy, done;
    logic [5:0]  num_bombs, safe_cell, randomValue, placed_count;
    logic [63:0] bomb_map;
`ifdef NEIGHBOR_COUNT_EN
    logic [5:0]  query_cell = 6'd0;
    logic [3:0]  query_count;
`endif

    bomb_placer dut (
        .clk(clk), .rst(rst), .start(start), .num_bombs(num_bombs),
        .safe_cell(safe_cell), .enable_random(enable_random),
        .randomValue(randomValue), .bomb_map(bomb_map),
        .placed_count(placed_count), .busy(busy),
`ifdef NEIGHBOR_COUNT_EN
        .query_cell(query_cell), .query_count(query_count),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] map; int cnt; int lat; } exp_t;
    exp_t exp_q[$];
    int   rnd_q[$];
    int   vals[$];
    int   tests = 0, fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Random source: the value presented is valid from the REQ cycle onward.
    always @(negedge clk) begin
        if (enable_random) begin
            if (rnd_q.size() > 0) randomValue = 6'(rnd_q.pop_front());
            else                  randomValue = 6'($urandom);
        end
    end

    int  bcnt = 0;
    bit  prev_en = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy) bcnt++;
        else      bcnt = 0;
        if (enable_random) check("enable_random_single_cycle", 64'(prev_en), 64'd0);
        prev_en = enable_random;
        if (done) begin
            check("done_with_busy", 64'(busy), 64'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("bomb_map", bomb_map, e.map);
                check("placed_count", 64'(placed_count), 64'(e.cnt));
                check("latency", 64'(bcnt), 64'(e.lat));
            end
        end
    end

    // Reference: each bomb starts at its random cell and walks forward (mod 64)
    // past occupied cells and the safe cell; every step costs one cycle.
    task automatic run_board(input int num, input int safe, input bit noise);
        exp_t e;
        logic [63:0] m;
        int lat, c, to;
        m = '0;
        lat = 1;
        for (int i = 0; i < num; i++) begin
            c = vals[i];
            lat += 2;
            while (m[c] || c == safe) begin
                c = (c + 1) % 64;
                lat++;
            end
            m[c] = 1'b1;
        end
        e.map = m; e.cnt = num; e.lat = lat;
        exp_q.push_back(e);
        rnd_q = vals;
        @(negedge clk);
        start = 1'b1; num_bombs = num[5:0]; safe_cell = safe[5:0];
        @(negedge clk);
        start = 1'b0;
        to = 0;
        while (busy && to < 10000) begin
            if (noise) begin
                num_bombs = 6'($urandom);
                safe_cell = 6'($urandom);
                start     = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            to++;
        end
        start = 1'b0;
        if (busy) begin
            check("board_timeout", 64'd1, 64'd0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int num, safe, hi;
        rst = 1'b1; start = 1'b0; num_bombs = '0; safe_cell = '0; randomValue = '0;
        repeat (2) @(negedge clk);
        check("rst_bomb_map", bomb_map, 64'd0);
        check("rst_placed_count", 64'(placed_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_enable_random", 64'(enable_random), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        vals = '{5, 9, 12};
        run_board(3, 0, 1'b0);
        check("basic_map", bomb_map, (64'd1 << 5) | (64'd1 << 9) | (64'd1 << 12));
        check("basic_count_hold", 64'(placed_count), 64'd3);

        vals = '{10, 10};
        run_board(2, 10, 1'b0);
        check("probe_map", bomb_map, (64'd1 << 11) | (64'd1 << 12));

        vals = '{63, 63};
        run_board(2, 5, 1'b0);
        check("wrap_map", bomb_map, (64'd1 << 63) | 64'd1);

        vals = {};
        for (int i = 0; i < 63; i++) vals.push_back(0);
        run_board(63, 27, 1'b0);
        check("full_map", bomb_map, ~(64'd1 << 27));

        vals = {};
        run_board(0, 3, 1'b0);
        check("zero_map", bomb_map, 64'd0);

        // Abort during PROBE: start, REQ, CHECK(10 is safe), PROBE.
        vals = '{10, 10};
        rnd_q = vals;
        @(negedge clk);
        start = 1'b1; num_bombs = 6'd2; safe_cell = 6'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_map", bomb_map, 64'd0);
        check("abort_count", 64'(placed_count), 64'd0);
        rnd_q.delete();
        repeat (5) @(negedge clk);

`ifdef NEIGHBOR_COUNT_EN
        vals = '{0, 1, 8};
        run_board(3, 63, 1'b0);
        query_cell = 6'd9;
        @(negedge clk);
        check("query_count", 64'(query_count), 64'd3);
`endif

        for (int b = 0; b < 25; b++) begin
            num  = (b % 6 == 0) ? 63 : $urandom_range(0, 63);
            safe = $urandom_range(0, 63);
            hi   = (b % 2 == 0) ? 7 : 63;
            vals = {};
            for (int i = 0; i < num; i++) vals.push_back($urandom_range(0, hi));
            run_board(num, safe, (b % 3 == 1));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bomb_placer.md
BOMB_PLACER -- requirements
Module: bomb_placer

Interface
REQ-001 The block SHALL have parameter: none; board fixed at 8x8 = 64 cells, index = row*8+col.
REQ-002 The block SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 The block SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  in  1  one-cycle request to build a new board; sampled only in IDLE.
REQ-005 The block SHALL have port num_bombs  in  6  bombs to place, sampled with start.
REQ-006 The block SHALL have port safe_cell  in  6  cell that never receives a bomb, sampled with start.
REQ-007 The block SHALL have port enable_random  out  1  request to random source to advance and present a value.
REQ-008 The block SHALL have port randomValue  in  6  random cell index, valid the cycle after enable_random.
REQ-009 The block SHALL have port bomb_map  out  64  bit i = 1 means bomb at cell i.
REQ-010 The block SHALL have port placed_count  out  6  bombs placed so far.
REQ-011 The block SHALL have port busy  out  1  high from start accept until done.
REQ-012 The block SHALL have port done  out  1  one-cycle pulse when board complete.

Function
REQ-013 The block SHALL implement states IDLE, REQ, CHECK, PROBE, FINISH.
REQ-014 IDLE + start: clear bomb_map and placed_count, latch num_bombs/safe_cell, busy=1; go to FINISH if num_bombs==0, else REQ.
REQ-015 REQ: drive enable_random=1 for exactly one cycle, then CHECK; enable_random SHALL be 0 in every other state.
REQ-016 CHECK: candidate = randomValue; if cell free and candidate != safe_cell, set bit, increment placed_count; else go to PROBE with candidate+1 mod 64.
REQ-017 PROBE: test one candidate per cycle; on free non-safe cell place bomb; else candidate+1 mod 64 (63 wraps to 0).
REQ-018 After a placement, if placed_count (new value) == num_bombs go to FINISH, else REQ.
REQ-019 FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE; bomb_map and placed_count hold until next start.
REQ-020 num_bombs=63 SHALL fill every cell except safe_cell; probing always terminates within 64 cycles per bomb.
REQ-021 start while busy SHALL be ignored; num_bombs/safe_cell changes while busy SHALL have no effect.
REQ-022 Latency: a bomb accepted in CHECK costs 2 cycles (REQ+CHECK); each probe step adds 1 cycle.

Reset
REQ-023 rst SHALL force IDLE, bomb_map=0, placed_count=0, busy=0, done=0, enable_random=0 on the next edge.
REQ-024 rst mid-operation SHALL abort the board; no done pulse SHALL be emitted for the aborted board.

Configuration
REQ-025 Macro NEIGHBOR_COUNT_EN SHALL add ports query_cell (in, 6) and query_count (out, 4).
REQ-026 With NEIGHBOR_COUNT_EN: query_count registered, 1-cycle latency, = number of bombs among the up to 8 neighbours of query_cell (no wrap across row/column edges), reset value 0.
REQ-027 Without NEIGHBOR_COUNT_EN: those ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 rst high 2 cycles -> bomb_map=0, placed_count=0, busy=0, done=0, enable_random=0.
REQ-029 start, num_bombs=3, safe_cell=0, randomValue 5,9,12 -> bomb_map bits 5,9,12 set, placed_count=3, done pulse 7 cycles after start.
REQ-030 num_bombs=2, safe_cell=10, randomValue 10 then 10 -> bombs at 11 and 12 via probing; cell 10 clear.
REQ-031 num_bombs=2, randomValue 63 then 63 -> bombs at 63 and 0 (wrap); placed_count=2.
REQ-032 num_bombs=63, safe_cell=27, randomValue constant 0 -> all bits set except 27, done pulse, no hang.
REQ-033 rst asserted during PROBE -> IDLE next cycle, bomb_map=0, no done; NEIGHBOR_COUNT_EN build: bombs at 0,1,8, query_cell=9 -> query_count=3 one cycle later.
